// File: rtl/issue_queue.sv
// In-order issue queue: captures operands at enqueue, wakes pending operands from the
// writeback bus, and issues the head entry once both operands are resolved.
package issue_queue_pkg;

    typedef struct packed {
        logic [31:0] num1;
        logic [31:0] num2;
        logic        num1_need;
        logic        num2_need;
        logic [4:0]  num1_addr;
        logic [4:0]  num2_addr;
        logic [1:0]  exe_type;
        logic [3:0]  alu_op;
        logic [2:0]  llu_op;
        logic [2:0]  mem_op;
        logic        write_reg_need;
        logic [4:0]  write_reg_addr;
        logic        predict_taken;
        logic [31:0] predict_target;
    } issue_queue_element_t;

endpackage

module issue_queue
    import issue_queue_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 flush_i,
    input  logic                 enq_valid_i,
    input  issue_queue_element_t enq_elem_i,
    output logic                 enq_ready_o,
    output logic [4:0]           rf_raddr1_o,
    output logic [4:0]           rf_raddr2_o,
    input  logic [31:0]          rf_rdata1_i,
    input  logic [31:0]          rf_rdata2_i,
    input  logic [31:0]          reg_busy_i,
    input  logic                 wb_valid_i,
    input  logic [4:0]           wb_addr_i,
    input  logic [31:0]          wb_data_i,
    output logic                 iss_valid_o,
    output issue_queue_element_t iss_elem_o,
    input  logic                 iss_ready_i
);

    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW = PtrW + 1;
    localparam logic [CntW-1:0] FullCnt = CntW'(DEPTH);

    issue_queue_element_t elem_q [DEPTH];
    issue_queue_element_t elem_d [DEPTH];
    logic [DEPTH-1:0]     valid_q, valid_d;
    logic [DEPTH-1:0]     rdy1_q, rdy1_d;
    logic [DEPTH-1:0]     rdy2_q, rdy2_d;
    logic [PtrW-1:0]      head_q, head_d;
    logic [PtrW-1:0]      tail_q, tail_d;
    logic [CntW-1:0]      count_q, count_d;

    logic                 dest_conflict;
    logic                 older_writes1, older_writes2;
    logic                 pend1, pend2;
    logic                 cap_rdy1, cap_rdy2;
    logic [31:0]          cap_num1, cap_num2;
    issue_queue_element_t cap_elem;
    logic                 enq_fire, deq_fire;

    // Returns {ready, value}; a same-cycle writeback beats any in-flight producer.
    function automatic logic [32:0] resolve_operand(
        input logic        need,
        input logic [4:0]  addr,
        input logic [31:0] imm,
        input logic [31:0] rf_data,
        input logic        pend,
        input logic        wb_v,
        input logic [4:0]  wb_a,
        input logic [31:0] wb_d
    );
        if (!need) begin
            return {1'b1, imm};
        end else if (addr == 5'd0) begin
            return {1'b1, 32'd0};
        end else if (wb_v && (wb_a == addr)) begin
            return {1'b1, wb_d};
        end else if (pend) begin
            return {1'b0, 32'd0};
        end else begin
            return {1'b1, rf_data};
        end
    endfunction

    assign rf_raddr1_o = enq_elem_i.num1_addr;
    assign rf_raddr2_o = enq_elem_i.num2_addr;

    always_comb begin
        dest_conflict = 1'b0;
        older_writes1 = 1'b0;
        older_writes2 = 1'b0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (valid_q[i] && elem_q[i].write_reg_need) begin
                if (enq_elem_i.write_reg_addr != 5'd0 &&
                    elem_q[i].write_reg_addr == enq_elem_i.write_reg_addr) begin
                    dest_conflict = 1'b1;
                end
                if (elem_q[i].write_reg_addr == enq_elem_i.num1_addr) begin
                    older_writes1 = 1'b1;
                end
                if (elem_q[i].write_reg_addr == enq_elem_i.num2_addr) begin
                    older_writes2 = 1'b1;
                end
            end
        end
    end

    assign pend1 = older_writes1 | reg_busy_i[enq_elem_i.num1_addr];
    assign pend2 = older_writes2 | reg_busy_i[enq_elem_i.num2_addr];

    assign {cap_rdy1, cap_num1} = resolve_operand(enq_elem_i.num1_need, enq_elem_i.num1_addr,
        enq_elem_i.num1, rf_rdata1_i, pend1, wb_valid_i, wb_addr_i, wb_data_i);
    assign {cap_rdy2, cap_num2} = resolve_operand(enq_elem_i.num2_need, enq_elem_i.num2_addr,
        enq_elem_i.num2, rf_rdata2_i, pend2, wb_valid_i, wb_addr_i, wb_data_i);

    always_comb begin
        cap_elem      = enq_elem_i;
        cap_elem.num1 = cap_num1;
        cap_elem.num2 = cap_num2;
    end

    assign enq_ready_o = !rst_i && (count_q != FullCnt) && !dest_conflict;
    assign iss_valid_o = valid_q[head_q] & rdy1_q[head_q] & rdy2_q[head_q];
    assign iss_elem_o  = valid_q[head_q] ? elem_q[head_q] : '0;
    assign enq_fire    = enq_valid_i && enq_ready_o;
    assign deq_fire    = iss_valid_o && iss_ready_i;

    always_comb begin
        elem_d  = elem_q;
        valid_d = valid_q;
        rdy1_d  = rdy1_q;
        rdy2_d  = rdy2_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush_i) begin
            valid_d = '0;
            rdy1_d  = '0;
            rdy2_d  = '0;
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (wb_valid_i && wb_addr_i != 5'd0) begin
                for (int i = 0; i < int'(DEPTH); i++) begin
                    if (valid_q[i] && !rdy1_q[i] && elem_q[i].num1_addr == wb_addr_i) begin
                        elem_d[i].num1 = wb_data_i;
                        rdy1_d[i]      = 1'b1;
                    end
                    if (valid_q[i] && !rdy2_q[i] && elem_q[i].num2_addr == wb_addr_i) begin
                        elem_d[i].num2 = wb_data_i;
                        rdy2_d[i]      = 1'b1;
                    end
                end
            end
            if (deq_fire) begin
                valid_d[head_q] = 1'b0;
                head_d          = head_q + PtrW'(1);
            end
            // Tail never aliases the dequeued head: enqueue is blocked when full.
            if (enq_fire) begin
                elem_d[tail_q]  = cap_elem;
                valid_d[tail_q] = 1'b1;
                rdy1_d[tail_q]  = cap_rdy1;
                rdy2_d[tail_q]  = cap_rdy2;
                tail_d          = tail_q + PtrW'(1);
            end
            count_d = count_q + CntW'(enq_fire) - CntW'(deq_fire);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q <= '0;
            rdy1_q  <= '0;
            rdy2_q  <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            valid_q <= valid_d;
            rdy1_q  <= rdy1_d;
            rdy2_q  <= rdy2_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Payload storage needs no reset; valid bits qualify every use.
    always_ff @(posedge clk_i) begin
        elem_q <= elem_d;
    end

endmodule

// File: tb/tb_issue_queue.sv
// Randomised and directed bench for issue_queue, with a queue-based reference model.
module tb_issue_queue;
    import issue_queue_pkg::*;

    localparam int DEPTH = 4;

    logic                 clk, rst, flush;
    logic                 enq_valid, enq_ready;
    issue_queue_element_t enq_elem, iss_elem;
    logic [4:0]           rf_raddr1, rf_raddr2;
    logic [31:0]          rf_rdata1, rf_rdata2, reg_busy;
    logic                 wb_valid;
    logic [4:0]           wb_addr;
    logic [31:0]          wb_data;
    logic                 iss_valid, iss_ready;

    issue_queue #(.DEPTH(DEPTH)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .flush_i     (flush),
        .enq_valid_i (enq_valid),
        .enq_elem_i  (enq_elem),
        .enq_ready_o (enq_ready),
        .rf_raddr1_o (rf_raddr1),
        .rf_raddr2_o (rf_raddr2),
        .rf_rdata1_i (rf_rdata1),
        .rf_rdata2_i (rf_rdata2),
        .reg_busy_i  (reg_busy),
        .wb_valid_i  (wb_valid),
        .wb_addr_i   (wb_addr),
        .wb_data_i   (wb_data),
        .iss_valid_o (iss_valid),
        .iss_elem_o  (iss_elem),
        .iss_ready_i (iss_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit                   enq_valid;
        issue_queue_element_t elem;
        logic [31:0]          rf1, rf2, busy;
        bit                   wb_valid;
        logic [4:0]           wb_addr;
        logic [31:0]          wb_data;
        bit                   iss_ready;
        bit                   flush;
    } stim_t;

    // An operand is either resolved (value known) or waiting for a write to its register.
    typedef struct {
        issue_queue_element_t e;
        bit                   p1, p2;
    } mentry_t;

    mentry_t model_q[$];
    mentry_t last_pop;
    bit      last_pop_v = 0;
    int      checks = 0;
    int      errors = 0;

    task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic bit dest_taken(input logic [4:0] a);
        if (a == 5'd0) return 0;
        foreach (model_q[i])
            if (model_q[i].e.write_reg_need && model_q[i].e.write_reg_addr == a) return 1;
        return 0;
    endfunction

    function automatic bit producer_in_flight(input logic [4:0] a, input logic [31:0] busy);
        if (busy[a]) return 1;
        if (last_pop_v && last_pop.e.write_reg_need && last_pop.e.write_reg_addr == a) return 1;
        foreach (model_q[i])
            if (model_q[i].e.write_reg_need && model_q[i].e.write_reg_addr == a) return 1;
        return 0;
    endfunction

    // Monitor: checks handshake outputs and pops the scoreboard on each issue.
    always @(negedge clk) begin : monitor
        bit exp_rdy, exp_iv;
        if (!rst) begin
            exp_rdy = (model_q.size() < DEPTH) && !dest_taken(enq_elem.write_reg_addr);
            chk("enq_ready", enq_ready, exp_rdy);
            exp_iv = (model_q.size() > 0) && !model_q[0].p1 && !model_q[0].p2;
            chk("iss_valid", iss_valid, exp_iv);
            chk("rf_raddr", {rf_raddr1, rf_raddr2}, {enq_elem.num1_addr, enq_elem.num2_addr});
            if (iss_valid && iss_ready) begin
                if (model_q.size() == 0) begin
                    chk("iss_underflow", 1, 0);
                end else begin
                    chk("iss_elem", iss_elem, model_q[0].e);
                    last_pop   = model_q.pop_front();
                    last_pop_v = 1;
                end
            end
        end
    end

    function automatic void resolve(input bit need, input logic [4:0] a, input logic [31:0] rf,
                                    input stim_t s, inout logic [31:0] num, output bit pend);
        pend = 0;
        if (!need) return;
        if (a == 5'd0) num = 32'd0;
        else if (s.wb_valid && s.wb_addr == a) num = s.wb_data;
        else if (producer_in_flight(a, s.busy)) pend = 1;
        else num = rf;
    endfunction

    task automatic step(input stim_t s);
        mentry_t n, t;
        bit      fire;
        @(posedge clk);
        #1;
        enq_valid = s.enq_valid;
        enq_elem  = s.elem;
        rf_rdata1 = s.rf1;
        rf_rdata2 = s.rf2;
        reg_busy  = s.busy;
        wb_valid  = s.wb_valid;
        wb_addr   = s.wb_addr;
        wb_data   = s.wb_data;
        iss_ready = s.iss_ready;
        flush     = s.flush;
        @(negedge clk);
        #1;
        fire = s.enq_valid && enq_ready;
        if (s.flush) begin
            model_q.delete();
        end else begin
            n.e = s.elem;
            resolve(s.elem.num1_need, s.elem.num1_addr, s.rf1, s, n.e.num1, n.p1);
            resolve(s.elem.num2_need, s.elem.num2_addr, s.rf2, s, n.e.num2, n.p2);
            if (s.wb_valid && s.wb_addr != 5'd0) begin
                foreach (model_q[i]) begin
                    t = model_q[i];
                    if (t.p1 && t.e.num1_addr == s.wb_addr) begin
                        t.e.num1 = s.wb_data;
                        t.p1     = 0;
                    end
                    if (t.p2 && t.e.num2_addr == s.wb_addr) begin
                        t.e.num2 = s.wb_data;
                        t.p2     = 0;
                    end
                    model_q[i] = t;
                end
            end
            if (fire) model_q.push_back(n);
        end
        last_pop_v = 0;
    endtask

    function automatic stim_t idle();
        stim_t s;
        s.enq_valid = 0;
        s.elem      = '0;
        s.rf1       = '0;
        s.rf2       = '0;
        s.busy      = '0;
        s.wb_valid  = 0;
        s.wb_addr   = '0;
        s.wb_data   = '0;
        s.iss_ready = 1;
        s.flush     = 0;
        return s;
    endfunction

    function automatic issue_queue_element_t mk(input bit n1, input logic [4:0] a1,
            input bit n2, input logic [4:0] a2, input logic [31:0] imm2, input logic [4:0] wd);
        issue_queue_element_t e;
        e                = '0;
        e.num1_need      = n1;
        e.num1_addr      = a1;
        e.num2_need      = n2;
        e.num2_addr      = a2;
        e.num2           = imm2;
        e.alu_op         = 4'd1;
        e.write_reg_need = (wd != 5'd0);
        e.write_reg_addr = wd;
        return e;
    endfunction

    function automatic stim_t rand_stim();
        stim_t s;
        s = idle();
        s.enq_valid           = ($urandom_range(0, 3) != 0);
        s.elem                = {$urandom, $urandom, $urandom, $urandom};
        s.elem.num1_addr      = 5'($urandom_range(0, 7));
        s.elem.num2_addr      = 5'($urandom_range(0, 7));
        s.elem.write_reg_addr = 5'($urandom_range(0, 7));
        s.rf1                 = $urandom;
        s.rf2                 = $urandom;
        for (int i = 0; i < 8; i++) s.busy[i] = ($urandom_range(0, 7) == 0);
        s.wb_valid            = $urandom_range(0, 1);
        s.wb_addr             = 5'($urandom_range(0, 7));
        s.wb_data             = $urandom;
        s.iss_ready           = ($urandom_range(0, 3) != 0);
        s.flush               = ($urandom_range(0, 40) == 0);
        return s;
    endfunction

    task automatic reset_check();
        #1;
        chk("rst_iss_valid", iss_valid, 0);
        chk("rst_enq_ready", enq_ready, 0);
        chk("rst_iss_elem", iss_elem, '0);
        model_q.delete();
        last_pop_v = 0;
    endtask

    initial begin
        stim_t s;
        rst = 1'b1;
        {flush, enq_valid, wb_valid, iss_ready} = '0;
        enq_elem = '0;
        {rf_rdata1, rf_rdata2, reg_busy, wb_data} = '0;
        wb_addr = '0;
        #2;
        reset_check();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // ADDIU r2 = r1 + 5
        s = idle(); s.enq_valid = 1; s.elem = mk(1, 1, 0, 0, 5, 2); s.rf1 = 10;
        step(s);
        repeat (2) step(idle());
        // ORI r3 = r2 | 1 while r2 is busy; writeback two cycles later
        s = idle(); s.enq_valid = 1; s.elem = mk(1, 2, 0, 0, 1, 3); s.busy[2] = 1;
        s.rf1 = 32'hdead;
        step(s);
        repeat (2) step(idle());
        s = idle(); s.wb_valid = 1; s.wb_addr = 2; s.wb_data = 32'h20;
        step(s);
        repeat (2) step(idle());
        // Same-cycle writeback beats reg_busy
        s = idle(); s.enq_valid = 1; s.elem = mk(1, 7, 0, 0, 3, 5); s.busy[7] = 1;
        s.wb_valid = 1; s.wb_addr = 7; s.wb_data = 32'h55; s.rf1 = 32'h99;
        step(s);
        repeat (2) step(idle());
        // Fill, then dequeue with a simultaneous offer
        for (int i = 0; i < 5; i++) begin
            s = idle(); s.iss_ready = 0; s.enq_valid = 1;
            s.elem = mk(0, 0, 0, 0, 32'(i), 5'(8 + i));
            step(s);
        end
        s = idle(); s.enq_valid = 1; s.elem = mk(0, 0, 0, 0, 32'h77, 20);
        step(s);
        step(s);
        repeat (6) step(idle());
        // Destination conflict on r4 held until the producer issues
        s = idle(); s.iss_ready = 0; s.enq_valid = 1; s.elem = mk(0, 0, 0, 0, 1, 4);
        step(s);
        s.elem.num2 = 2;
        repeat (3) step(s);
        s.iss_ready = 1;
        repeat (3) step(s);
        repeat (3) step(idle());
        // Flush with three entries and a simultaneous enqueue
        for (int i = 0; i < 3; i++) begin
            s = idle(); s.iss_ready = 0; s.enq_valid = 1;
            s.elem = mk(0, 0, 0, 0, 32'(i), 5'(16 + i));
            step(s);
        end
        s = idle(); s.iss_ready = 0; s.enq_valid = 1; s.flush = 1;
        s.elem = mk(0, 0, 0, 0, 32'hf, 25);
        step(s);
        repeat (2) step(idle());

        for (int i = 0; i < 1500; i++) step(rand_stim());

        // Asynchronous reset mid-operation
        s = rand_stim(); s.flush = 0; s.iss_ready = 0;
        step(s);
        #2 rst = 1'b1;
        reset_check();
        enq_valid = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        for (int i = 0; i < 1500; i++) step(rand_stim());
        repeat (4) step(idle());

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/issue_queue.md
ISSUE_QUEUE -- requirements
Module: issue_queue

Interface
REQ-001 Parameter DEPTH, default 4, number of queue entries; SHALL be a power of two.
REQ-002 clk  in  1  rising-edge clock for all state.
REQ-003 rst  in  1  asynchronous, active-high reset.
REQ-004 flush  in  1  discards all entries (branch mispredict recovery).
REQ-005 enq_valid  in  1  decoder offers an element.
REQ-006 enq_elem  in  ISSUE_QUEUE_ELEMENT  decoded element: num1/num2, *_need, *_addr, exe/alu/llu/mem fields, write_reg_*, predict_*.
REQ-007 enq_ready  out  1  queue can accept this cycle.
REQ-008 rf_raddr1, rf_raddr2  out  5  register-file read addresses, driven combinationally from enq_elem.num1_addr and enq_elem.num2_addr.
REQ-009 rf_rdata1, rf_rdata2  in  32  register-file read data, same cycle.
REQ-010 reg_busy  in  32  scoreboard: bit r set while an already-issued instruction will still write register r.
REQ-011 wb_valid  in  1; wb_addr  in  5; wb_data  in  32  result broadcast bus.
REQ-012 iss_valid  out  1  head element is issuable.
REQ-013 iss_elem  out  ISSUE_QUEUE_ELEMENT  head element with num1/num2 holding resolved operand values.
REQ-014 iss_ready  in  1  execute stage accepts.

Function
REQ-015 Storage: DEPTH entries; per entry, element, valid, rdy1, rdy2; head/tail pointers of log2(DEPTH) bits wrap modulo DEPTH; count of log2(DEPTH)+1 bits.
REQ-016 Enqueue fires when enq_valid && enq_ready; the element is written at tail, tail increments, and it is visible at the head no earlier than the next cycle.
REQ-017 enq_ready = !rst && count<DEPTH && no valid entry has write_reg_need with write_reg_addr equal to a nonzero enq_elem.write_reg_addr; it is independent of iss_ready in the same cycle.
REQ-018 Operand k capture at enqueue: need_k=0 -> keep enq num_k, rdy_k=1; addr_k=0 -> value 0, rdy_k=1; wb_valid && wb_addr==addr_k -> wb_data, rdy_k=1; older valid queue entry writes addr_k, or reg_busy[addr_k] -> rdy_k=0; otherwise rf_rdata_k, rdy_k=1.
REQ-019 The wb match SHALL take priority over the reg_busy and older-entry pending checks.
REQ-020 Wake-up: each cycle, for every valid entry with rdy_k=0, a wb_valid with wb_addr==addr_k writes wb_data into num_k and sets rdy_k=1; the effect appears from the next cycle.
REQ-021 Issue is strictly in order: iss_valid = head valid && rdy1 && rdy2; iss_elem = head entry contents, registered, with no wb bypass to the output.
REQ-022 Dequeue fires when iss_valid && iss_ready; the head entry is invalidated and head increments.
REQ-023 Simultaneous enqueue and dequeue leave count unchanged; with count==1, the new entry becomes head the following cycle.
REQ-024 Flush clears all valid bits, head, tail and count in the next cycle, takes priority over enqueue, dequeue and wake-up in that cycle, and iss_valid=0 in the cycle after.
REQ-025 wb_addr==0 never wakes an entry; register 0 is always ready with value 0.

Reset
REQ-026 rst asserted at any time, including mid-operation, SHALL asynchronously clear all valid/rdy bits, head=0, tail=0 and count=0, giving iss_valid=0, iss_elem all-zero and enq_ready=0 while rst is high.
REQ-027 The first enqueue is accepted on the first rising edge after rst deasserts.

Verification
REQ-028 ADDIU r2=r1+5 enqueued with rf_rdata1=10 and reg_busy=0 -> next cycle iss_valid=1, num1=10, num2=5.
REQ-029 ORI r3=r2|1 enqueued with reg_busy[2]=1; two cycles later wb r2=0x20 -> iss_valid=0 until the cycle after wb, then num1=0x20.
REQ-030 Enqueue with wb_valid, wb_addr=addr1=7, wb_data=0x55 in the same cycle -> rdy1=1, num1=0x55.
REQ-031 Four enqueues with iss_ready=0 -> enq_ready=0 with count=4; one dequeue plus simultaneous offer -> enq_ready returns the next cycle and issue order is preserved.
REQ-032 Enqueue of dest r4 while a queued entry writes r4 -> enq_ready=0 until that entry issues.
REQ-033 flush with 3 entries plus simultaneous enqueue -> next cycle count=0, iss_valid=0, and the enqueued element is discarded.
